write_dest_queue: RTL and testbench

WRITE_DEST_QUEUE -- requirements
Module: write_dest_queue

---
 rtl/write_dest_queue_if.sv | 47 ++++
 rtl/write_dest_queue.sv | 131 +++++++++++++
 tb/tb_write_dest_queue.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/write_dest_queue_if.sv
// write_dest_queue_if
//   Groups the write-request handshake, the register-bank write port, and the
//   forwarding lookup used by write_dest_queue.
//   master : the pipeline/driver side (issues requests, consumes head entry)
//   slave  : the queue itself
//   Signals:
//     rt, rd, rs, BancoWriteReg    destination candidates and select
//     wr_valid, wr_data, wr_ready  write request handshake
//     rf_we, rf_addr, rf_data      head entry toward the register bank
//     rf_ready                     register bank consumes head this cycle
//     rd_addr_a, fwd_hit_a,
//     fwd_data_a                   forwarding lookup
//     count, sel_err               occupancy and sticky invalid-select flag
interface write_dest_queue_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IDX_W-1:0]  rt;
  logic [IDX_W-1:0]  rd;
  logic [IDX_W-1:0]  rs;
  logic [2:0]        BancoWriteReg;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rf_we;
  logic [IDX_W-1:0]  rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              rf_ready;
  logic [IDX_W-1:0]  rd_addr_a;
  logic              fwd_hit_a;
  logic [DATA_W-1:0] fwd_data_a;
  logic [CNT_W-1:0]  count;
  logic              sel_err;

  modport master (
    output rt, rd, rs, BancoWriteReg, wr_valid, wr_data, rf_ready, rd_addr_a,
    input  wr_ready, rf_we, rf_addr, rf_data, fwd_hit_a, fwd_data_a, count, sel_err
  );

  modport slave (
    input  rt, rd, rs, BancoWriteReg, wr_valid, wr_data, rf_ready, rd_addr_a,
    output wr_ready, rf_we, rf_addr, rf_data, fwd_hit_a, fwd_data_a, count, sel_err
  );
endinterface

// File: rtl/write_dest_queue.sv
// write_dest_queue
//   Queue of pending register-bank writes. Each accepted request resolves its
//   destination index from BancoWriteReg (rt/rd/rs/29/31) and is stored with
//   its data; the head entry is presented to the register bank until it is
//   consumed. Writes to register 0 are acknowledged but dropped; invalid
//   selects are acknowledged, dropped, and latch sel_err until reset.
//   Optional forwarding lookup of pending writes is enabled by the macro
//   WRITE_DEST_FWD_EN; without it fwd_hit_a/fwd_data_a are tied to 0.
//   Ports:
//     clk   : single clock, rising edge
//     reset : asynchronous, active-high
//     bus   : write_dest_queue_if.slave (request, bank port, lookup, status)
module write_dest_queue #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  write_dest_queue_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [IDX_W-1:0]  r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              r_sel_err;

  logic [IDX_W-1:0]  w_dest;
  logic              w_sel_bad;
  logic              w_ready;
  logic              w_accept;
  logic              w_enq;
  logic              w_deq;
  logic              w_nonempty;

  always_comb begin
    w_dest    = '0;
    w_sel_bad = 1'b0;
    case (bus.BancoWriteReg)
      3'd0:    w_dest = bus.rt;
      3'd1:    w_dest = bus.rd;
      3'd2:    w_dest = bus.rs;
      3'd3:    w_dest = IDX_W'(29);
      3'd4:    w_dest = IDX_W'(31);
      default: w_sel_bad = 1'b1;
    endcase
  end

  assign w_nonempty = (r_count != '0);
  assign w_ready    = (r_count < CW'(DEPTH));
  assign w_accept   = bus.wr_valid && w_ready;
  // Register 0 and invalid selects complete the handshake but never occupy a slot.
  assign w_enq      = w_accept && !w_sel_bad && (w_dest != '0);
  assign w_deq      = w_nonempty && bus.rf_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_sel_err <= 1'b0;
      r_vld     <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_addr[k] <= '0;
        r_data[k] <= '0;
      end
    end else begin
      // enq and deq never target the same slot: enq needs not-full, deq needs not-empty.
      if (w_enq) begin
        r_addr[r_tail] <= w_dest;
        r_data[r_tail] <= bus.wr_data;
        r_vld[r_tail]  <= 1'b1;
        r_tail         <= r_tail + PW'(1);
      end
      if (w_deq) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_accept && w_sel_bad) begin
        r_sel_err <= 1'b1;
      end
    end
  end

  assign bus.wr_ready = w_ready;
  assign bus.rf_we    = w_nonempty;
  assign bus.rf_addr  = w_nonempty ? r_addr[r_head] : '0;
  assign bus.rf_data  = w_nonempty ? r_data[r_head] : '0;
  assign bus.count    = r_count;
  assign bus.sel_err  = r_sel_err;

`ifdef WRITE_DEST_FWD_EN
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;
  logic [PW-1:0]     v_idx;

  // Walk from oldest to youngest so the last match (youngest) wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    v_idx      = r_head;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      v_idx = r_head + PW'(k);
      if (r_vld[v_idx] && (bus.rd_addr_a != '0) && (r_addr[v_idx] == bus.rd_addr_a)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[v_idx];
      end
    end
  end

  assign bus.fwd_hit_a  = w_fwd_hit;
  assign bus.fwd_data_a = w_fwd_data;
`else
  logic w_unused_fwd;
  assign w_unused_fwd   = ^{bus.rd_addr_a, r_vld};
  assign bus.fwd_hit_a  = 1'b0;
  assign bus.fwd_data_a = '0;
`endif

endmodule

// File: tb/tb_write_dest_queue.sv
module tb_write_dest_queue;

  localparam int DATA_W = 32;
  localparam int IDX_W  = 5;
  localparam int DEPTH  = 4;

`ifdef WRITE_DEST_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic reset;

  write_dest_queue_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) bus ();

  write_dest_queue #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        valid;
    logic [31:0] data;
    logic        rfr;
    logic        exp_ready;   // combinational, before the edge
    logic [2:0]  exp_count;   // after the edge
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] sel, input logic [4:0] rt, input logic [4:0] rd,
                              input logic valid, input logic [31:0] data, input logic rfr,
                              input logic er, input logic [2:0] ec, input logic ew,
                              input logic [4:0] ea, input logic [31:0] ed, input logic ee);
    vec_t v;
    v.sel = sel; v.rt = rt; v.rd = rd; v.valid = valid; v.data = data; v.rfr = rfr;
    v.exp_ready = er; v.exp_count = ec; v.exp_we = ew; v.exp_addr = ea; v.exp_data = ed;
    v.exp_err = ee;
    return v;
  endfunction

  vec_t vecs[14];

  // Reference queue for the multi-cycle sequences.
  logic [4:0]  mq_a[$];
  logic [31:0] mq_d[$];

  // One cycle with sel=1 (destination = rd = a); checks against the reference queue.
  task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d, input logic rfr);
    logic acc;
    logic deq;
    @(negedge clk);
    bus.BancoWriteReg = 3'd1;
    bus.rd       = a;
    bus.wr_valid = v;
    bus.wr_data  = d;
    bus.rf_ready = rfr;
    #1;
    acc = v && (mq_a.size() < DEPTH);
    deq = (mq_a.size() != 0) && rfr;
    check("seq_wr_ready", {31'd0, bus.wr_ready}, {31'd0, mq_a.size() < DEPTH});
    check("seq_rf_we", {31'd0, bus.rf_we}, {31'd0, mq_a.size() != 0});
    if (mq_a.size() != 0) begin
      check("seq_rf_addr", {27'd0, bus.rf_addr}, {27'd0, mq_a[0]});
      check("seq_rf_data", bus.rf_data, mq_d[0]);
    end
    @(posedge clk);
    if (deq) begin
      void'(mq_a.pop_front());
      void'(mq_d.pop_front());
    end
    if (acc && a != 5'd0) begin
      mq_a.push_back(a);
      mq_d.push_back(d);
    end
    #1;
    check("seq_count", {29'd0, bus.count}, 32'(mq_a.size()));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset             = 1'b1;
    bus.rt            = 5'd3;
    bus.rd            = 5'd8;
    bus.rs            = 5'd12;
    bus.BancoWriteReg = 3'd0;
    bus.wr_valid      = 1'b0;
    bus.wr_data       = '0;
    bus.rf_ready      = 1'b0;
    bus.rd_addr_a     = '0;

    vecs[0]  = mk(3'd1, 5'd3, 5'd8, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b1, 3'd1, 1'b1, 5'd8,  32'hA5A5A5A5, 1'b0);
    vecs[1]  = mk(3'd1, 5'd3, 5'd8, 1'b0, 32'h0,        1'b1, 1'b1, 3'd0, 1'b0, 5'd0,  32'h0,        1'b0);
    vecs[2]  = mk(3'd0, 5'd0, 5'd8, 1'b1, 32'hDEAD,     1'b0, 1'b1, 3'd0, 1'b0, 5'd0,  32'h0,        1'b0);
    vecs[3]  = mk(3'd6, 5'd0, 5'd8, 1'b1, 32'hBEEF,     1'b0, 1'b1, 3'd0, 1'b0, 5'd0,  32'h0,        1'b1);
    vecs[4]  = mk(3'd0, 5'd3, 5'd8, 1'b0, 32'h0,        1'b0, 1'b1, 3'd0, 1'b0, 5'd0,  32'h0,        1'b1);
    vecs[5]  = mk(3'd3, 5'd7, 5'd8, 1'b1, 32'h1,        1'b0, 1'b1, 3'd1, 1'b1, 5'd29, 32'h1,        1'b1);
    vecs[6]  = mk(3'd4, 5'd7, 5'd8, 1'b1, 32'h2,        1'b0, 1'b1, 3'd2, 1'b1, 5'd29, 32'h1,        1'b1);
    vecs[7]  = mk(3'd0, 5'd7, 5'd8, 1'b1, 32'h3,        1'b0, 1'b1, 3'd3, 1'b1, 5'd29, 32'h1,        1'b1);
    vecs[8]  = mk(3'd0, 5'd7, 5'd8, 1'b1, 32'h4,        1'b0, 1'b1, 3'd4, 1'b1, 5'd29, 32'h1,        1'b1);
    vecs[9]  = mk(3'd0, 5'd7, 5'd8, 1'b1, 32'h5,        1'b0, 1'b0, 3'd4, 1'b1, 5'd29, 32'h1,        1'b1);
    vecs[10] = mk(3'd0, 5'd7, 5'd8, 1'b1, 32'h6,        1'b1, 1'b0, 3'd3, 1'b1, 5'd31, 32'h2,        1'b1);
    vecs[11] = mk(3'd0, 5'd7, 5'd8, 1'b0, 32'h0,        1'b1, 1'b1, 3'd2, 1'b1, 5'd7,  32'h3,        1'b1);
    vecs[12] = mk(3'd0, 5'd7, 5'd8, 1'b0, 32'h0,        1'b1, 1'b1, 3'd1, 1'b1, 5'd7,  32'h4,        1'b1);
    vecs[13] = mk(3'd0, 5'd7, 5'd8, 1'b0, 32'h0,        1'b1, 1'b1, 3'd0, 1'b0, 5'd0,  32'h0,        1'b1);

    // Outputs while reset is held.
    #2;
    check("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
    check("rst_rf_we",    {31'd0, bus.rf_we},    32'd0);
    check("rst_count",    {29'd0, bus.count},    32'd0);
    check("rst_sel_err",  {31'd0, bus.sel_err},  32'd0);
    check("rst_rf_addr",  {27'd0, bus.rf_addr},  32'd0);
    check("rst_rf_data",  bus.rf_data,           32'd0);
    check("rst_fwd_hit",  {31'd0, bus.fwd_hit_a}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Table: single write latency, reg-0 drop, invalid select, fill/overflow, drain order.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus.BancoWriteReg = vecs[i].sel;
      bus.rt            = vecs[i].rt;
      bus.rd            = vecs[i].rd;
      bus.wr_valid      = vecs[i].valid;
      bus.wr_data       = vecs[i].data;
      bus.rf_ready      = vecs[i].rfr;
      #1;
      check($sformatf("v%0d_wr_ready", i), {31'd0, bus.wr_ready}, {31'd0, vecs[i].exp_ready});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_count", i),   {29'd0, bus.count},   {29'd0, vecs[i].exp_count});
      check($sformatf("v%0d_rf_we", i),   {31'd0, bus.rf_we},   {31'd0, vecs[i].exp_we});
      check($sformatf("v%0d_rf_addr", i), {27'd0, bus.rf_addr}, {27'd0, vecs[i].exp_addr});
      check($sformatf("v%0d_rf_data", i), bus.rf_data,          vecs[i].exp_data);
      check($sformatf("v%0d_sel_err", i), {31'd0, bus.sel_err}, {31'd0, vecs[i].exp_err});
    end

    // Forwarding: two pending writes to reg 5, youngest must be returned.
    step(1'b1, 5'd5, 32'h11, 1'b0);
    step(1'b1, 5'd5, 32'h22, 1'b0);
    @(negedge clk);
    bus.wr_valid  = 1'b0;
    bus.rd_addr_a = 5'd5;
    #1;
    check("fwd5_hit",  {31'd0, bus.fwd_hit_a}, {31'd0, FWD});
    check("fwd5_data", bus.fwd_data_a, FWD ? 32'h22 : 32'h0);
    bus.rd_addr_a = 5'd0;
    #1;
    check("fwd0_hit",  {31'd0, bus.fwd_hit_a}, 32'd0);
    check("fwd0_data", bus.fwd_data_a, 32'd0);
    bus.rd_addr_a = 5'd6;
    #1;
    check("fwd6_hit",  {31'd0, bus.fwd_hit_a}, 32'd0);
    bus.rd_addr_a = 5'd5;
    step(1'b0, 5'd0, 32'h0, 1'b1);
    check("fwd5_after_pop_hit",  {31'd0, bus.fwd_hit_a}, {31'd0, FWD});
    check("fwd5_after_pop_data", bus.fwd_data_a, FWD ? 32'h22 : 32'h0);
    step(1'b0, 5'd0, 32'h0, 1'b1);
    check("fwd5_empty_hit", {31'd0, bus.fwd_hit_a}, 32'd0);
    bus.rd_addr_a = 5'd0;

    // Full queue, then concurrent enqueue/dequeue across pointer wrap, then drain.
    for (int i = 0; i < 4; i++) step(1'b1, 5'(10 + i), 32'h100 + 32'(i), 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 5'(16 + i), 32'h200 + 32'(i), 1'b1);
      check("wrap_count_min", {31'd0, bus.count >= 3'd3}, 32'd1);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 5'd0, 32'h0, 1'b1);
    check("wrap_drained", {29'd0, bus.count}, 32'd0);

    // Asynchronous reset mid-cycle with three entries pending.
    for (int i = 0; i < 3; i++) step(1'b1, 5'(20 + i), 32'h300 + 32'(i), 1'b0);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_rf_we",    {31'd0, bus.rf_we},    32'd0);
    check("arst_count",    {29'd0, bus.count},    32'd0);
    check("arst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
    check("arst_rf_addr",  {27'd0, bus.rf_addr},  32'd0);
    check("arst_rf_data",  bus.rf_data,           32'd0);
    check("arst_sel_err",  {31'd0, bus.sel_err},  32'd0);
    #1;
    reset = 1'b0;
    mq_a.delete();
    mq_d.delete();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd0, 32'h0, 1'b1);
      check("post_rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
